// File: rtl/btn_event_counter_bank.sv
// btn_event_counter_bank
//   Multi-channel button front end: 2-flop synchroniser, debounce FSM,
//   edge detect, per-channel event counters with clear, wrap/saturate,
//   sticky overflow and a frame-aligned snapshot of all counters.
//   Optional auto-repeat on held buttons: define BTN_EVT_AUTO_REPEAT_EN.
module btn_event_counter_bank #(
  parameter int NUM_CH        = 3,
  parameter int DB_CYCLES     = 1000000,
  parameter int CNT_WIDTH     = 16,
  parameter int EDGE_MODE     = 0,
  parameter int SATURATE      = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_CH-1:0]             btn_in,
  input  logic [NUM_CH-1:0]             clr,
  input  logic                          frame_sync,
  input  logic                          freeze,
  output logic [NUM_CH-1:0]             btn_level,
  output logic [NUM_CH-1:0]             btn_edge,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_live,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_snap,
  output logic                          snap_valid,
  output logic [NUM_CH-1:0]             overflow
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  // Elaboration-time sanity of the configuration.
  if (DB_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_event_counter_bank: invalid DB_CYCLES / REPEAT_* configuration");
  end

  typedef enum logic {DB_STABLE, DB_PENDING} db_state_t;

  logic [NUM_CH-1:0]    sync_meta;
  logic [NUM_CH-1:0]    sync_q;
  logic [NUM_CH-1:0]    level_q;
  logic [NUM_CH-1:0]    level_nx;
  logic [NUM_CH-1:0]    level_d;
  db_state_t            db_state    [NUM_CH];
  db_state_t            db_state_nx [NUM_CH];
  logic [DBW-1:0]       db_cnt      [NUM_CH];
  logic [DBW-1:0]       db_cnt_nx   [NUM_CH];
  logic [NUM_CH-1:0]    edge_sel;
  logic [NUM_CH-1:0]    rep_pulse;
  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q;
  logic                 fs_d;
  logic                 snap_valid_q;

  // Synchroniser, debounce state and level registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      level_d   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        db_state[i] <= DB_STABLE;
        db_cnt[i]   <= '0;
      end
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
      level_q   <= level_nx;
      level_d   <= level_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        db_state[i] <= db_state_nx[i];
        db_cnt[i]   <= db_cnt_nx[i];
      end
    end
  end

  // Debounce next-state: counting starts on the first mismatching cycle so a
  // clean step reaches btn_level DB_CYCLES+2 edges after it is first sampled.
  always_comb begin
    level_nx = level_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      db_state_nx[i] = db_state[i];
      db_cnt_nx[i]   = '0;
      unique case (db_state[i])
        DB_STABLE: begin
          if (sync_q[i] != level_q[i]) begin
            db_state_nx[i] = DB_PENDING;
            db_cnt_nx[i]   = DBW'(1);
          end
        end
        DB_PENDING: begin
          if (sync_q[i] == level_q[i]) begin
            db_state_nx[i] = DB_STABLE;
          end else if (db_cnt[i] == DB_LAST) begin
            level_nx[i]    = ~level_q[i];
            db_state_nx[i] = DB_STABLE;
          end else begin
            db_cnt_nx[i] = db_cnt[i] + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BTN_EVT_AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [HW-1:0] hold_cnt [NUM_CH];

  // Hold counters: 0 on the press-edge cycle, reload after each repeat so the
  // next one lands REPEAT_PERIOD cycles later.
  always_ff @(posedge sys_clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!sys_rst_n || !level_q[i] || clr[i]) begin
        hold_cnt[i] <= '0;
      end else if (hold_cnt[i] == HOLD_FIRE) begin
        hold_cnt[i] <= HOLD_RELOAD;
      end else begin
        hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  // Repeat pulses, only for modes that count rising edges.
  always_comb begin
    rep_pulse = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rep_pulse[i] = (EDGE_MODE != 1) && level_q[i] && (hold_cnt[i] == HOLD_FIRE);
    end
  end
`else
  // No auto-repeat: only genuine debounced edges.
  always_comb begin
    rep_pulse = '0;
  end
`endif

  // Edge detect filtered by EDGE_MODE, merged with repeat pulses.
  always_comb begin
    case (EDGE_MODE)
      0:       edge_sel = level_q & ~level_d;
      1:       edge_sel = ~level_q & level_d;
      default: edge_sel = level_q ^ level_d;
    endcase
    btn_edge = edge_sel | rep_pulse;
  end

  // Event counters: clear wins over a coincident edge.
  always_ff @(posedge sys_clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!sys_rst_n || clr[i]) begin
        cnt_q[i] <= '0;
        ovf_q[i] <= 1'b0;
      end else if (btn_edge[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_q[i] <= 1'b1;
          if (SATURATE == 0) begin
            cnt_q[i] <= '0;
          end
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Snapshot on frame_sync rising edge unless frozen.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      fs_d         <= 1'b0;
      snap_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      fs_d         <= frame_sync;
      snap_valid_q <= frame_sync && !fs_d && !freeze;
      if (frame_sync && !fs_d && !freeze) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          snap_q[i] <= cnt_q[i];
        end
      end
    end
  end

  // Output packing.
  always_comb begin
    cnt_live = '0;
    cnt_snap = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_live[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      cnt_snap[i*CNT_WIDTH +: CNT_WIDTH] = snap_q[i];
    end
    btn_level  = level_q;
    overflow   = ovf_q;
    snap_valid = snap_valid_q;
  end

endmodule
